// File: rtl/pipe_stage_hs_pkg.sv
// Shared pipeline types: boundary payload structs and the elastic-stage occupancy states.
package pipe_stage_hs_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pstage_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   reg_data1;
        logic [XLEN-1:0]   reg_data2;
        logic [XLEN-1:0]   imm_ext;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [6:0]        opcode;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]   wb_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } mem_wb_t;

endpackage

// File: rtl/id_ex_hs.sv
// ID/EX boundary: elastic stage carrying the id_ex_t payload struct.
// Exposes the perf counters when PIPE_STAGE_PERF_EN is defined.
module id_ex_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  id_ex_t           in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output id_ex_t           out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    logic [$bits(id_ex_t)-1:0] w_out_data;

    pipe_stage_hs #(
        .DATA_W     ($bits(id_ex_t)),
        .CLEAR_DATA (CLEAR_DATA),
        .CNT_W      (CNT_W)
    ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (w_out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    assign out_data = id_ex_t'(w_out_data);

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready pipeline register with a one-entry skid buffer and synchronous flush.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    pstage_state_t     r_state;
    pstage_state_t     w_state_nxt;
    logic [DATA_W-1:0] r_main_d;
    logic [DATA_W-1:0] r_skid_d;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;
    logic              w_clr_main;
    logic              w_clr_skid;

    // Ready depends only on the state register, never on out_ready.
    assign in_ready   = (r_state != PS_TWO);
    assign out_valid  = (r_state != PS_EMPTY);
    assign out_data   = r_main_d;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        w_clr_main     = 1'b0;
        w_clr_skid     = 1'b0;
        if (flush) begin
            w_state_nxt = PS_EMPTY;
            w_clr_main  = 1'b1;
            w_clr_skid  = 1'b1;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt  = PS_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = PS_TWO;
                        w_ld_skid   = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = PS_EMPTY;
                        w_clr_main  = 1'b1;
                    end
                end
                PS_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt    = PS_ONE;
                        w_ld_main_skid = 1'b1;
                        w_clr_skid     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = PS_EMPTY;
                    w_clr_main  = 1'b1;
                    w_clr_skid  = 1'b1;
                end
            endcase
        end
    end

    // With CLEAR_DATA=0 only the occupancy is cleared; payload keeps its stale value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_d <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_d <= r_skid_d;
            end else if (CLEAR_DATA && w_clr_main) begin
                r_main_d <= '0;
            end
            if (w_ld_skid) begin
                r_skid_d <= in_data;
            end else if (CLEAR_DATA && w_clr_skid) begin
                r_skid_d <= '0;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!out_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule
